// File: rtl/ltssm_trace_recorder.sv
// Link-training trace recorder: timestamps every change of the (ltssm, speed, width)
// tuple and queues it in a first-word-fall-through FIFO drained over valid/ready.
module ltssm_trace_recorder #(
   parameter int LTSSM_W = 6,
   parameter int TS_W    = 32,
   parameter int DEPTH   = 16,
   parameter int REC_W   = TS_W + LTSSM_W + 6
) (
   input  logic                   clk_host_1p0g,
   input  logic                   rst_host_1p0g,
   input  logic [LTSSM_W-1:0]     ltssm_state,
   input  logic [2:0]             link_speed,
   input  logic [2:0]             link_width,
   input  logic                   trace_en,
   input  logic                   clear,
   output logic                   rec_valid,
   input  logic                   rec_ready,
   output logic [REC_W-1:0]       rec_data,
   output logic [$clog2(DEPTH):0] rec_count,
   output logic                   overflow,
   output logic [15:0]            drop_cnt
);

   localparam int TUP_W = LTSSM_W + 6;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t             state;
   state_t             state_nxt;
   logic               push_req;
   logic [TS_W-1:0]    ts;
   logic [TUP_W-1:0]   tuple;
   logic [TUP_W-1:0]   last_tuple;

   logic [REC_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               pop;
   logic               push_ok;
   logic               drop;

   assign tuple     = {ltssm_state, link_speed, link_width};
   assign rec_valid = (count != '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign pop       = rec_valid && rec_ready;
   // A push into a full FIFO survives only if the head leaves on the same edge.
   assign push_ok   = push_req && (!full || pop);
   assign drop      = push_req && full && !pop;
   assign rec_data  = rec_valid ? mem[rd_ptr] : '0;
   assign rec_count = count;

   always_ff @(posedge clk_host_1p0g or posedge rst_host_1p0g) begin
      if (rst_host_1p0g) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      push_req  = 1'b0;
      case (state)
         IDLE: begin
            if (trace_en) state_nxt = PRIME;
         end
         PRIME: begin
            push_req  = 1'b1;
            state_nxt = trace_en ? RUN : IDLE;
         end
         RUN: begin
            push_req = (tuple != last_tuple);
            if (!trace_en) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_host_1p0g or posedge rst_host_1p0g) begin
      if (rst_host_1p0g) begin
         ts         <= '0;
         last_tuple <= '0;
      end else begin
         ts         <= clear ? '0 : ts + TS_W'(1);
         last_tuple <= tuple;
      end
   end

   // clear outranks both push and pop; a push lost to clear is not a drop.
   always_ff @(posedge clk_host_1p0g or posedge rst_host_1p0g) begin
      if (rst_host_1p0g) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (push_ok && !pop) begin
            count <= count + CNT_W'(1);
         end else if (!push_ok && pop) begin
            count <= count - CNT_W'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc16(drop_cnt);
         end
      end
   end

   always_ff @(posedge clk_host_1p0g) begin
      if (push_ok && !clear) mem[wr_ptr] <= {ts, tuple};
   end

endmodule

// File: tb/tb_ltssm_trace_recorder.sv
// Bench for ltssm_trace_recorder: a 32-bit-timestamp and a 4-bit-timestamp instance
// share stimulus; a behavioural model feeds an expected-record queue drained by a monitor.
module tb_ltssm_trace_recorder;

   localparam int LW    = 6;
   localparam int TSW   = 32;
   localparam int TSW_S = 4;
   localparam int DEPTH = 16;
   localparam int RW    = TSW + LW + 6;
   localparam int RW_S  = TSW_S + LW + 6;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [LW-1:0] ltssm = '0;
   logic [2:0]    spd = '0;
   logic [2:0]    wid = '0;
   logic          en = 1'b0;
   logic          clr = 1'b0;
   logic          rdy = 1'b0;

   logic          rec_valid, rec_valid_s;
   logic [RW-1:0] rec_data;
   logic [RW_S-1:0] rec_data_s;
   logic [CW-1:0] rec_count, rec_count_s;
   logic          overflow, overflow_s;
   logic [15:0]   drop_cnt, drop_cnt_s;

   ltssm_trace_recorder #(.LTSSM_W(LW), .TS_W(TSW), .DEPTH(DEPTH)) dut (
      .clk_host_1p0g(clk), .rst_host_1p0g(rst), .ltssm_state(ltssm),
      .link_speed(spd), .link_width(wid), .trace_en(en), .clear(clr),
      .rec_valid(rec_valid), .rec_ready(rdy), .rec_data(rec_data),
      .rec_count(rec_count), .overflow(overflow), .drop_cnt(drop_cnt));

   ltssm_trace_recorder #(.LTSSM_W(LW), .TS_W(TSW_S), .DEPTH(DEPTH)) dut_s (
      .clk_host_1p0g(clk), .rst_host_1p0g(rst), .ltssm_state(ltssm),
      .link_speed(spd), .link_width(wid), .trace_en(en), .clear(clr),
      .rec_valid(rec_valid_s), .rec_ready(rdy), .rec_data(rec_data_s),
      .rec_count(rec_count_s), .overflow(overflow_s), .drop_cnt(drop_cnt_s));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] ts;
      logic [11:0] tup;
   } rec_t;

   rec_t        exp_q[$];
   int          n_chk = 0;
   int          n_err = 0;

   // Reference model state
   int          m_mode = 0;  // 0 off, 1 taking snapshot, 2 watching for changes
   logic [31:0] m_ts = '0;
   logic [11:0] m_last = '0;
   int          m_cnt = 0;
   logic        m_ovf = 1'b0;
   int          m_drop = 0;
   logic [11:0] m_cur;
   bit          m_want;
   bit          m_pop;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_mode = 0; m_ts = '0; m_last = '0; m_cnt = 0;
            m_ovf = 1'b0; m_drop = 0; exp_q.delete();
         end else begin
            m_cur  = {ltssm, spd, wid};
            m_want = 1'b0;
            if (m_mode == 0) begin
               if (en) m_mode = 1;
            end else if (m_mode == 1) begin
               m_want = 1'b1;
               m_mode = en ? 2 : 0;
            end else begin
               m_want = (m_cur != m_last);
               if (!en) m_mode = 0;
            end
            m_pop = rdy && (m_cnt > 0);
            if (clr) begin
               exp_q.delete(); m_cnt = 0; m_ovf = 1'b0; m_drop = 0;
            end else begin
               if (m_pop) m_cnt--;
               if (m_want) begin
                  if (m_cnt < DEPTH) begin
                     exp_q.push_back('{ts: m_ts, tup: m_cur});
                     m_cnt++;
                  end else begin
                     m_ovf = 1'b1;
                     if (m_drop < 65535) m_drop++;
                  end
               end
            end
            m_ts   = clr ? 32'd0 : m_ts + 32'd1;
            m_last = m_cur;
         end
      end
   end

   logic          prev_stall = 1'b0;
   logic [RW-1:0] prev_data = '0;

   initial begin
      forever begin
         @(negedge clk);
         chk("valid", rec_valid, exp_q.size() != 0);
         chk("valid_s", rec_valid_s, exp_q.size() != 0);
         chk("count", rec_count, m_cnt);
         chk("count_s", rec_count_s, m_cnt);
         chk("overflow", overflow, m_ovf);
         chk("drop_cnt", drop_cnt, m_drop);
         chk("drop_cnt_s", drop_cnt_s, m_drop);
         if (prev_stall && rec_valid) chk("stall_stable", rec_data, prev_data);
         if (exp_q.size() != 0) begin
            chk("data", rec_data, {exp_q[0].ts, exp_q[0].tup});
            chk("data_s", rec_data_s, {exp_q[0].ts[TSW_S-1:0], exp_q[0].tup});
            if (rec_valid && rdy) void'(exp_q.pop_front());
         end else begin
            chk("data_empty", rec_data, '0);
         end
         prev_stall = rec_valid && !rdy && !clr && !rst;
         prev_data  = rec_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   logic [31:0] prev_ts;
   logic [LW-1:0] run_seq [4] = '{6'h00, 6'h01, 6'h02, 6'h11};

   initial begin
      // Snapshot after reset release
      en = 1'b1; ltssm = 6'h11; spd = 3'b001; wid = 3'b100;
      repeat (2) step();
      chk("reset_count", rec_count, 0);
      chk("reset_valid", rec_valid, 0);
      rst = 1'b0;
      step();
      step();
      chk("snapshot", rec_data, {32'd1, 6'h11, 3'b001, 3'b100});
      repeat (4) step();
      chk("stable_count", rec_count, 1);

      // Consecutive changes with the consumer always ready
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ltssm = run_seq[i];
         step();
         chk("run_valid", rec_valid, 1);
         chk("run_ltssm", rec_data[11:6], run_seq[i]);
         if (i > 0) chk("run_ts_step", rec_data[RW-1:12], prev_ts + 32'd1);
         prev_ts = rec_data[RW-1:12];
      end
      step();

      // Overflow: snapshot plus nineteen changes into a stalled FIFO
      en = 1'b0; step();
      clr = 1'b1; step();
      clr = 1'b0; rdy = 1'b0; en = 1'b1; step();
      for (int i = 0; i < 20; i++) begin
         ltssm = 6'h20 + LW'(i);
         step();
      end
      chk("ovf_count", rec_count, 16);
      chk("ovf_flag", overflow, 1);
      chk("ovf_drops", drop_cnt, 4);
      chk("first_is_snapshot", rec_data[11:6], 6'h20);
      for (int i = 0; i < 40; i++) begin
         rdy = 1'($urandom_range(0, 1));
         step();
      end
      rdy = 1'b1;
      repeat (20) step();
      chk("drained", rec_count, 0);

      // Full FIFO with push and pop on the same edge
      rdy = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ltssm = LW'(i);
         step();
      end
      chk("full_count", rec_count, 16);
      ltssm = 6'h3F; rdy = 1'b1;
      step();
      chk("pushpop_count", rec_count, 16);
      chk("pushpop_drops", drop_cnt, 4);
      repeat (15) step();
      chk("last_entry", rec_data[11:6], 6'h3F);
      step();

      // clear together with a change, five entries queued
      rdy = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         ltssm = LW'(i);
         step();
      end
      chk("five_count", rec_count, 5);
      clr = 1'b1; ltssm = 6'h0A;
      step();
      clr = 1'b0;
      chk("clr_count", rec_count, 0);
      chk("clr_valid", rec_valid, 0);
      chk("clr_drops", drop_cnt, 0);
      chk("clr_ovf", overflow, 0);
      ltssm = 6'h0B;
      step();
      chk("clr_change_lost", rec_count, 1);
      chk("ts_restart", rec_data, {32'd0, 6'h0B, 3'b001, 3'b100});

      // Narrow timestamp wrap: changes in the cycles with ts=15 and ts=16
      rdy = 1'b1;
      repeat (14) step();
      rdy = 1'b0; ltssm = 6'h15;
      step();
      ltssm = 6'h16;
      step();
      chk("wrap_ts15", rec_data_s[RW_S-1:12], 15);
      chk("wide_ts15", rec_data[RW-1:12], 15);
      rdy = 1'b1;
      step();
      chk("wrap_ts0", rec_data_s[RW_S-1:12], 0);
      chk("wide_ts16", rec_data[RW-1:12], 16);
      step();

      // Randomised traffic with occasional clear and reset
      for (int i = 0; i < 3000; i++) begin
         en  = ($urandom_range(0, 19) != 0);
         clr = ($urandom_range(0, 199) == 0);
         rst = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 3) == 0) ltssm = LW'($urandom);
         if ($urandom_range(0, 7) == 0) spd = 3'($urandom);
         if ($urandom_range(0, 7) == 0) wid = 3'($urandom);
         rdy = ((i / 100) % 3 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
         step();
      end
      rst = 1'b0; clr = 1'b0; en = 1'b0; rdy = 1'b1;
      repeat (30) step();
      chk("final_empty", rec_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ltssm_trace_recorder.md
Name: ltssm_trace_recorder

Overview:
- Hardware counterpart to the bench LTSSM monitor: the on-chip writer of link-training history.
- Samples the endpoint LTSSM state, link speed and link width each cycle.
- On every change it timestamps the new (ltssm, speed, width) tuple and writes it into a trace FIFO.
- Host-side logic drains the FIFO over a valid/ready interface, so training sequences can be replayed in silicon, not only in simulation.

Parameters:
- LTSSM_W, 6, width of the LTSSM state code.
- TS_W, 32, width of the free-running timestamp, in clk_host_1p0g cycles.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- REC_W, TS_W+LTSSM_W+6, record width (derived; not to be overridden).

Ports:
- clk_host_1p0g, in, 1: the block's only clock.
- rst_host_1p0g, in, 1: asynchronous, active-high reset.
- ltssm_state, in, LTSSM_W: endpoint LTSSM code, synchronous to clk_host_1p0g.
- link_speed, in, 3: negotiated speed (common[49:47] encoding).
- link_width, in, 3: negotiated width (common[46:44] encoding).
- trace_en, in, 1: capture enable.
- clear, in, 1: synchronous flush; single-cycle pulse.
- rec_valid, out, 1: FIFO head is valid.
- rec_ready, in, 1: consumer accepts the head.
- rec_data, out, REC_W: {timestamp, ltssm, speed, width}, MSB to LSB.
- rec_count, out, $clog2(DEPTH)+1: current occupancy.
- overflow, out, 1: sticky; at least one record was dropped.
- drop_cnt, out, 16: dropped-record count, saturating.

Behaviour:
- Reset values: rec_valid=0, rec_data=0, rec_count=0, overflow=0, drop_cnt=0, timestamp=0, last_tuple=0, FSM=IDLE.
- Timestamp: increments every cycle, wraps from 2^TS_W-1 to 0. Reset by clear or by reset only; trace_en has no effect on it.
- last_tuple register: loaded with {ltssm_state, link_speed, link_width} on every edge, in every state.
- FSM:
  - IDLE: no pushes. trace_en=1 -> PRIME.
  - PRIME: one cycle. Unconditionally pushes {ts, current tuple} as the snapshot, then goes to RUN; goes to IDLE instead if trace_en=0.
  - RUN: pushes {ts, current tuple} at any edge where the current tuple differs from last_tuple. trace_en=0 -> IDLE; pending pushes on that edge still occur.
- Push latency: a tuple that changes in cycle N is written at the end of cycle N and can appear on rec_valid/rec_data in cycle N+1 (when the FIFO was empty). The timestamp stored is the counter value in cycle N.
- FIFO read side:
  - First-word fall-through; rec_data holds the head whenever rec_valid=1.
  - Pop occurs when rec_valid && rec_ready.
  - rec_data is stable while rec_valid=1 && rec_ready=0.
  - rec_data is 0 when the FIFO is empty.
- Full FIFO:
  - A push with no simultaneous pop is dropped: drop_cnt increments (saturates at 16'hFFFF) and overflow is set.
  - A push with a simultaneous pop is accepted; the count is unchanged and nothing is dropped.
- Empty FIFO: a pop request is ignored.
- Pointers wrap modulo DEPTH; rec_count ranges 0..DEPTH.
- clear (has priority over push and pop in the same cycle): empties the FIFO, zeroes drop_cnt, overflow and timestamp. It does not change the FSM state or last_tuple. The push that would have occurred on that edge is discarded and not counted as a drop.
- Reset asserted mid-operation: every register returns to its reset value immediately (asynchronously); FIFO contents are discarded.
- Inputs are assumed already synchronous to clk_host_1p0g; no CDC inside the block.

Test Plan:
- Reset release with trace_en=1 and tuple {0x11,3'b001,3'b100} held: exactly one snapshot record appears, with ts=1 and tuple 0x11/001/100; no further records while the tuple is stable.
- In RUN, ltssm steps 0x00->0x01->0x02->0x11 on consecutive cycles, rec_ready=1: four records with consecutive timestamps, each appearing one cycle after its change.
- rec_ready=0, DEPTH=16, twenty changes: rec_count=16, overflow=1, drop_cnt=4. Then drain 16 records in order with rec_data stable while stalled; the first record is the snapshot.
- FIFO full with a change and a pop on the same edge: rec_count stays 16, drop_cnt unchanged; the new record appears as the last entry.
- clear pulsed together with a tuple change, FIFO holding 5 entries: rec_count=0, rec_valid=0, drop_cnt=0, overflow=0, timestamp restarts at 0; the simultaneous change is not recorded.
- Timestamp preloaded near wrap (TS_W=4 build), change at ts=15 then at ts=0: the stored timestamps are 15 then 0.
